// File: rtl/corefifo_pkg.sv
// Shared definitions for the FIFO pointer synchroniser family.
//   MIN_NUM_STAGES / MAX_NUM_STAGES     : legal synchroniser depth range
//   MIN_NUM_CHANNELS / MAX_NUM_CHANNELS : legal channel-count range
//   MAX_PTR_W                           : widest pointer the helpers handle
//   gray2bin()                          : Gray-to-binary decode. Callers zero-extend
//                                         their pointer to MAX_PTR_W bits, so one
//                                         function serves any ADDRWIDTH.
//   popcount()                          : number of set bits, used by the optional
//                                         Gray-violation check
package corefifo_pkg;

   localparam int unsigned MIN_NUM_STAGES   = 2;
   localparam int unsigned MAX_NUM_STAGES   = 4;
   localparam int unsigned MIN_NUM_CHANNELS = 1;
   localparam int unsigned MAX_NUM_CHANNELS = 8;
   localparam int unsigned MAX_PTR_W        = 32;

   // Leading zeros decode to zeros, so a zero-extended pointer decodes correctly
   // in its low bits.
   function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] gray);
      logic [MAX_PTR_W-1:0] bin;
      bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
      for (int k = MAX_PTR_W - 2; k >= 0; k--) begin
         bin[k] = bin[k+1] ^ gray[k];
      end
      return bin;
   endfunction

   function automatic logic [5:0] popcount(input logic [MAX_PTR_W-1:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int k = 0; k < MAX_PTR_W; k++) begin
         cnt = cnt + 6'(v[k]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/corefifo_ptr_sync_chan.sv
// One channel of the FIFO pointer synchroniser.
//   clk_i    : destination-domain clock
//   arstn_i  : asynchronous active-low reset
//   srstn_i  : synchronous active-low clear
//   gray_i   : source-domain Gray pointer (ADDRWIDTH+1 bits)
//   gray_o   : synchronised Gray pointer (last stage flop)
//   bin_o    : registered binary decode of gray_o
//   chg_o    : one-cycle pulse on the edge where bin_o changes
//   err_o    : sticky Gray-violation flag. It is only implemented when
//              COREFIFO_PTR_SYNC_ERRCHK_EN is defined and is tied to 0 otherwise.
module corefifo_ptr_sync_chan
   import corefifo_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 2,
   parameter int unsigned ADDRWIDTH  = 3
) (
   input  logic                 clk_i,
   input  logic                 arstn_i,
   input  logic                 srstn_i,
   input  logic [ADDRWIDTH:0]   gray_i,
   output logic [ADDRWIDTH:0]   gray_o,
   output logic [ADDRWIDTH:0]   bin_o,
   output logic                 chg_o,
   output logic                 err_o
);

   localparam int unsigned W = ADDRWIDTH + 1;

   logic [W-1:0] stage_q [NUM_STAGES];
   logic [W-1:0] bin_q;
   logic [W-1:0] bin_d;
   logic         chg_q;
   logic         chg_d;

   // Decode the last stage. The flop that captures it makes sync_bin one
   // edge later than sync_gray.
   assign bin_d = W'(gray2bin(MAX_PTR_W'(stage_q[NUM_STAGES-1])));
   assign chg_d = (bin_d != bin_q);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int i = 0; i < int'(NUM_STAGES); i++) stage_q[i] <= '0;
         bin_q <= '0;
         chg_q <= 1'b0;
      end else if (!srstn_i) begin
         for (int i = 0; i < int'(NUM_STAGES); i++) stage_q[i] <= '0;
         bin_q <= '0;
         chg_q <= 1'b0;
      end else begin
         stage_q[0] <= gray_i;
         for (int i = 1; i < int'(NUM_STAGES); i++) stage_q[i] <= stage_q[i-1];
         bin_q <= bin_d;
         chg_q <= chg_d;
      end
   end

   assign gray_o = stage_q[NUM_STAGES-1];
   assign bin_o  = bin_q;
   assign chg_o  = chg_q;

`ifdef COREFIFO_PTR_SYNC_ERRCHK_EN
   logic [W-1:0] prev_q;
   logic [2:0]   blank_q;
   logic         err_q;

   // The blanking counter reloads on every reset. It hides the settling of
   // the chain, so the check only looks at a freshly refilled pipeline.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         prev_q  <= '0;
         blank_q <= 3'(NUM_STAGES + 1);
         err_q   <= 1'b0;
      end else if (!srstn_i) begin
         prev_q  <= '0;
         blank_q <= 3'(NUM_STAGES + 1);
         err_q   <= 1'b0;
      end else begin
         prev_q <= stage_q[NUM_STAGES-1];
         if (blank_q != 3'd0) begin
            blank_q <= blank_q - 3'd1;
         end else if (popcount(MAX_PTR_W'(stage_q[NUM_STAGES-1] ^ prev_q)) > 6'd1) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: rtl/corefifo_ptr_sync_multi.sv
// Multi-channel FIFO pointer synchroniser. It carries NUM_CHANNELS Gray-coded
// pointers into the clk domain through NUM_STAGES flops. For each channel it
// also produces a registered binary decode and a change pulse.
// Optional feature macro: COREFIFO_PTR_SYNC_ERRCHK_EN enables the sticky
// per-channel Gray-violation flag. When the macro is undefined, sync_err is
// tied to 0.
// Ports:
//   clk       : destination-domain clock
//   arstn     : asynchronous active-low reset (has priority over srstn)
//   srstn     : synchronous active-low clear
//   inp_gray  : packed source pointers. Channel c is at [c*(ADDRWIDTH+1) +: ADDRWIDTH+1]
//   sync_gray : synchronised Gray pointers, same packing as inp_gray
//   sync_bin  : registered binary decode of sync_gray
//   sync_chg  : per-channel change pulse aligned with sync_bin
//   sync_err  : per-channel sticky Gray-violation flag
module corefifo_ptr_sync_multi
   import corefifo_pkg::*;
#(
   parameter int unsigned NUM_STAGES   = 2,
   parameter int unsigned ADDRWIDTH    = 3,
   parameter int unsigned NUM_CHANNELS = 1
) (
   input  logic                                  clk,
   input  logic                                  arstn,
   input  logic                                  srstn,
   input  logic [NUM_CHANNELS*(ADDRWIDTH+1)-1:0] inp_gray,
   output logic [NUM_CHANNELS*(ADDRWIDTH+1)-1:0] sync_gray,
   output logic [NUM_CHANNELS*(ADDRWIDTH+1)-1:0] sync_bin,
   output logic [NUM_CHANNELS-1:0]               sync_chg,
   output logic [NUM_CHANNELS-1:0]               sync_err
);

   localparam int unsigned W = ADDRWIDTH + 1;

   if (NUM_STAGES < MIN_NUM_STAGES || NUM_STAGES > MAX_NUM_STAGES) begin : g_bad_stages
      $error("corefifo_ptr_sync_multi: NUM_STAGES must be in 2..4");
   end
   if (NUM_CHANNELS < MIN_NUM_CHANNELS || NUM_CHANNELS > MAX_NUM_CHANNELS) begin : g_bad_channels
      $error("corefifo_ptr_sync_multi: NUM_CHANNELS must be in 1..8");
   end
   if (ADDRWIDTH < 1 || W > MAX_PTR_W) begin : g_bad_width
      $error("corefifo_ptr_sync_multi: ADDRWIDTH out of supported range");
   end

   for (genvar c = 0; c < int'(NUM_CHANNELS); c++) begin : g_chan
      corefifo_ptr_sync_chan #(
         .NUM_STAGES (NUM_STAGES),
         .ADDRWIDTH  (ADDRWIDTH)
      ) u_chan (
         .clk_i   (clk),
         .arstn_i (arstn),
         .srstn_i (srstn),
         .gray_i  (inp_gray[c*W +: W]),
         .gray_o  (sync_gray[c*W +: W]),
         .bin_o   (sync_bin[c*W +: W]),
         .chg_o   (sync_chg[c]),
         .err_o   (sync_err[c])
      );
   end

endmodule
